// File: rtl/ix_stage.sv
// rtl/ix_stage.sv - execute stage: operand forwarding, ALU, branch compare, optional RV32M unit
// IX_MULDIV_EN enables the iterative multiply/divide unit and its ix_stall handshake.
module ix_stage #(
  parameter int MUL_FAST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] dataR1_in,
  input  logic [31:0] dataR2_in,
  input  logic [31:0] imm_ext_in,
  input  logic [31:0] inst_in,
  input  logic        BrUn_in,
  input  logic        Asel_in,
  input  logic        Bsel_in,
  input  logic [3:0]  ALUSel_in,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [31:0] mem_fwd,
  input  logic [31:0] wb_fwd,
  output logic [31:0] alu_out,
  output logic [31:0] rs2_fwd_out,
  output logic        br_eq,
  output logic        br_lt,
  output logic        ix_stall
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [4:0]  shamt;

  always_comb begin
    case (fwd_a_sel)
      2'b01:   fwd_a = mem_fwd;
      2'b10:   fwd_a = wb_fwd;
      default: fwd_a = dataR1_in;
    endcase
    case (fwd_b_sel)
      2'b01:   fwd_b = mem_fwd;
      2'b10:   fwd_b = wb_fwd;
      default: fwd_b = dataR2_in;
    endcase
  end

  assign op_a        = Asel_in ? pc_in : fwd_a;
  assign op_b        = Bsel_in ? imm_ext_in : fwd_b;
  assign shamt       = op_b[4:0];
  assign rs2_fwd_out = fwd_b;

  // Branch compare always sees the forwarded register operands, never pc/imm.
  assign br_eq = (fwd_a == fwd_b);
  assign br_lt = BrUn_in ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));

  always_comb begin
    alu_res = 32'd0;
    case (ALUSel_in)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {31'd0, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = 32'd0;
    endcase
  end

`ifdef IX_MULDIV_EN

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  f3_q, f3_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;

  logic        is_md;
  logic [2:0]  f3;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        fast_mul;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_cand;
  logic [32:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] fast_prod;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] md_res;
  logic        md_stall;
  logic        md_valid;
  logic        unused_inst;

  assign unused_inst = ^{inst_in[24:15], inst_in[11:7]};

  assign is_md = (inst_in[6:0] == 7'b0110011) && (inst_in[31:25] == 7'b0000001);
  assign f3    = inst_in[14:12];

  // MULH/MULHSU/DIV/REM take rs1 as signed; MULH/DIV/REM also rs2. MUL low word is sign-agnostic.
  assign a_neg = fwd_a[31] && ((f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110));
  assign b_neg = fwd_b[31] && ((f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110));
  assign mag_a = a_neg ? (32'd0 - fwd_a) : fwd_a;
  assign mag_b = b_neg ? (32'd0 - fwd_b) : fwd_b;

  assign fast_mul = (MUL_FAST != 0) && !f3_q[2];

  // Shift-add: low half of acc holds the remaining multiplier bits, high half the partial sum.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_step = {mul_sum, acc_q[31:1]};

  // Restoring divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign div_cand = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_cand - {1'b0, opb_q};
  assign div_step = div_diff[32] ? {div_cand[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign fast_prod = {32'd0, opb_q} * {32'd0, acc_q[31:0]};

  assign prod = neg_res_q ? (64'd0 - acc_q) : acc_q;
  assign quo  = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
  assign rem  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    md_res = 32'd0;
    case (f3_q)
      3'b000:                 md_res = prod[31:0];
      3'b001, 3'b010, 3'b011: md_res = prod[63:32];
      3'b100, 3'b101:         md_res = quo;
      default:                md_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    f3_d      = f3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    md_stall  = 1'b0;
    md_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_md && !flush_in && rst) begin
          md_stall  = 1'b1;
          state_d   = ST_BUSY;
          cnt_d     = 5'd0;
          acc_d     = {32'd0, mag_a};
          opb_d     = mag_b;
          f3_d      = f3;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (fwd_b == 32'd0);
        end
      end
      ST_BUSY: begin
        md_stall = 1'b1;
        cnt_d    = cnt_q + 5'd1;
        if (f3_q[2]) begin
          acc_d = div_step;
        end else if (fast_mul) begin
          acc_d = fast_prod;
        end else begin
          acc_d = mul_step;
        end
        if ((cnt_q == 5'd31) || fast_mul) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        md_valid = !flush_in;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A redirect discards whatever is in flight, including a result about to complete.
    if (flush_in) begin
      state_d = ST_IDLE;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      f3_q      <= 3'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      f3_q      <= f3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign ix_stall = md_stall;
  assign alu_out  = md_valid ? md_res : alu_res;

`else

  logic unused_md;

  assign unused_md = ^{clk, rst, flush_in, inst_in, (MUL_FAST != 0)};
  assign ix_stall  = 1'b0;
  assign alu_out   = alu_res;

`endif

endmodule

// File: tb/tb_ix_stage.sv
// tb/tb_ix_stage.sv - randomized self-checking bench for ix_stage against a behavioural model
// Mul/div scenarios are exercised when IX_MULDIV_EN is defined; otherwise funct7=1 ops run as ALU ops.
module tb_ix_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_in;
  logic [31:0] pc_in, dataR1_in, dataR2_in, imm_ext_in, inst_in;
  logic        BrUn_in, Asel_in, Bsel_in;
  logic [3:0]  ALUSel_in;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] mem_fwd, wb_fwd;
  logic [31:0] alu_out, rs2_fwd_out;
  logic        br_eq, br_lt, ix_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ix_stage dut (
    .clk(clk), .rst(rst), .flush_in(flush_in), .pc_in(pc_in),
    .dataR1_in(dataR1_in), .dataR2_in(dataR2_in), .imm_ext_in(imm_ext_in), .inst_in(inst_in),
    .BrUn_in(BrUn_in), .Asel_in(Asel_in), .Bsel_in(Bsel_in), .ALUSel_in(ALUSel_in),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .alu_out(alu_out), .rs2_fwd_out(rs2_fwd_out), .br_eq(br_eq), .br_lt(br_lt),
    .ix_stall(ix_stall)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] md_inst(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'b01) return m;
    if (sel == 2'b10) return w;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
    int sa, sb;
    logic [4:0] sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return sa >>> sh;
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ua; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic idle_inputs();
    flush_in = 1'b0; pc_in = 32'd0; dataR1_in = 32'd0; dataR2_in = 32'd0;
    imm_ext_in = 32'd0; inst_in = NOP; BrUn_in = 1'b0; Asel_in = 1'b0; Bsel_in = 1'b0;
    ALUSel_in = 4'd0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; mem_fwd = 32'd0; wb_fwd = 32'd0;
  endtask

  // Presents a mul/div op and counts stalled cycles until the result cycle.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] res);
    @(negedge clk);
    idle_inputs();
    dataR1_in = a; dataR2_in = b; inst_in = md_inst(f3);
    #1;
    n = 0;
    while (ix_stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    res = alu_out;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    dataR1_in = 32'd5; dataR2_in = 32'd7; inst_in = md_inst(3'd4);
    #12;
    checks++;
    if (ix_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", ix_stall); end
    checks++;
    if (alu_out !== 32'd12) begin errors++; $display("FAIL reset_alu: got %h want 0000000c", alu_out); end
    @(negedge clk);
    inst_in = NOP;
    rst = 1'b1;
  endtask

  task automatic test_alu_directed();
    @(negedge clk);
    idle_inputs();
    dataR1_in = 32'd5; dataR2_in = 32'd7;
    #1;
    checks++;
    if (alu_out !== 32'd12 || ix_stall !== 1'b0) begin
      errors++; $display("FAIL add_5_7: got %h stall %b want 0000000c stall 0", alu_out, ix_stall);
    end
    ALUSel_in = 4'd1;
    #1;
    checks++;
    if (alu_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_5_7: got %h want fffffffe", alu_out); end
    dataR1_in = 32'hFFFF_FFFF; dataR2_in = 32'd1; BrUn_in = 1'b0;
    #1;
    checks++;
    if (br_lt !== 1'b1) begin errors++; $display("FAIL br_lt_signed: got %b want 1", br_lt); end
    BrUn_in = 1'b1;
    #1;
    checks++;
    if (br_lt !== 1'b0) begin errors++; $display("FAIL br_lt_unsigned: got %b want 0", br_lt); end
    dataR1_in = 32'd3; dataR2_in = 32'd3;
    #1;
    checks++;
    if (br_eq !== 1'b1) begin errors++; $display("FAIL br_eq: got %b want 1", br_eq); end
    idle_inputs();
    fwd_a_sel = 2'b01; mem_fwd = 32'h100; Bsel_in = 1'b1; imm_ext_in = 32'd4;
    fwd_b_sel = 2'b10; wb_fwd = 32'd9;
    #1;
    checks++;
    if (alu_out !== 32'h104) begin errors++; $display("FAIL fwd_mem: got %h want 00000104", alu_out); end
    checks++;
    if (rs2_fwd_out !== 32'd9) begin errors++; $display("FAIL fwd_wb_rs2: got %h want 00000009", rs2_fwd_out); end
  endtask

  // Random ALU traffic; allow_md lets funct7=1 encodings through (only meaningful without the unit).
  task automatic test_alu_random(input bit allow_md);
    logic [31:0] fa, fb, ea, eb, exp;
    int sa, sb;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pc_in = $urandom; dataR1_in = $urandom; dataR2_in = $urandom; imm_ext_in = $urandom;
      mem_fwd = $urandom; wb_fwd = $urandom;
      if (i % 5 == 0) dataR2_in = dataR1_in;
      BrUn_in = 1'($urandom); Asel_in = 1'($urandom); Bsel_in = 1'($urandom);
      ALUSel_in = 4'($urandom); fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
      inst_in = allow_md ? md_inst(3'($urandom)) : {$urandom} & 32'hFFFF_FF80 | 32'h13;
      #1;
      fa = ref_fwd(fwd_a_sel, dataR1_in, mem_fwd, wb_fwd);
      fb = ref_fwd(fwd_b_sel, dataR2_in, mem_fwd, wb_fwd);
      ea = Asel_in ? pc_in : fa;
      eb = Bsel_in ? imm_ext_in : fb;
      exp = ref_alu(ea, eb, ALUSel_in);
      sa = fa;
      sb = fb;
      checks++;
      if (alu_out !== exp || ix_stall !== 1'b0) begin
        errors++;
        $display("FAIL alu_rand[%0d] op %0d: got %h stall %b want %h stall 0", i, ALUSel_in, alu_out, ix_stall, exp);
      end
      checks++;
      if (rs2_fwd_out !== fb) begin errors++; $display("FAIL rs2_fwd[%0d]: got %h want %h", i, rs2_fwd_out, fb); end
      checks++;
      if (br_eq !== (fa == fb) || br_lt !== (BrUn_in ? (fa < fb) : (sa < sb))) begin
        errors++; $display("FAIL branch[%0d]: got eq %b lt %b want eq %b lt %b", i, br_eq, br_lt,
                           fa == fb, BrUn_in ? (fa < fb) : (sa < sb));
      end
    end
  endtask

`ifdef IX_MULDIV_EN
  task automatic test_muldiv_basic();
    int n;
    logic [31:0] r;
    run_md(3'd4, 32'd100, 32'd7, n, r);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL div_latency: got %0d cycles want 33", n); end
    checks++;
    if (r !== 32'd14) begin errors++; $display("FAIL div_100_7: got %h want 0000000e", r); end
    run_md(3'd6, 32'd100, 32'd7, n, r);
    checks++;
    if (r !== 32'd2 || n !== 33) begin errors++; $display("FAIL rem_100_7: got %h in %0d want 00000002 in 33", r, n); end
    run_md(3'd3, 32'hFFFF_FFFF, 32'd2, n, r);
    checks++;
    if (r !== 32'd1 || n !== 33) begin errors++; $display("FAIL mulhu: got %h in %0d want 00000001 in 33", r, n); end
  endtask

  task automatic test_div_special();
    int n;
    logic [31:0] r;
    logic [2:0]  f3s [4]  = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run_md(f3s[i], as[i], bs[i], n, r);
      checks++;
      if (r !== want[i] || n !== 33) begin
        errors++; $display("FAIL div_special[%0d]: got %h in %0d want %h in 33", i, r, n, want[i]);
      end
    end
  endtask

  task automatic test_muldiv_random();
    int n;
    logic [31:0] a, b, r, exp;
    logic [2:0]  f3;
    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'd0;  1: a = 32'hFFFF_FFFF;  2: a = 32'h8000_0000;  default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;  1: b = 32'hFFFF_FFFF;  2: b = $urandom_range(1, 20);  default: b = $urandom;
      endcase
      exp = ref_md(f3, a, b);
      run_md(f3, a, b, n, r);
      checks++;
      if (r !== exp || n !== 33) begin
        errors++; $display("FAIL md_rand[%0d] f3 %0d %h,%h: got %h in %0d want %h in 33", i, f3, a, b, r, n, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] r;
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, n, r);
    checks++;
    if (r !== 32'hFFFF_FFFF || n !== 33) begin errors++; $display("FAIL b2b_mulh: got %h in %0d want ffffffff in 33", r, n); end
    run_md(3'd0, 32'd6, 32'hFFFF_FFFD, n, r);
    checks++;
    if (r !== 32'hFFFF_FFEE || n !== 33) begin errors++; $display("FAIL b2b_mul: got %h in %0d want ffffffee in 33", r, n); end
    @(negedge clk);
    idle_inputs();
    dataR1_in = 32'd20; dataR2_in = 32'd22;
    #1;
    checks++;
    if (alu_out !== 32'd42 || ix_stall !== 1'b0) begin
      errors++; $display("FAIL after_md_alu: got %h stall %b want 0000002a stall 0", alu_out, ix_stall);
    end
  endtask

  task automatic test_flush();
    int n;
    logic [31:0] r;
    @(negedge clk);
    idle_inputs();
    dataR1_in = 32'd1000; dataR2_in = 32'd3; inst_in = md_inst(3'd4);
    repeat (11) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0; inst_in = NOP;
    #1;
    checks++;
    if (ix_stall !== 1'b0 || alu_out !== 32'd1003) begin
      errors++; $display("FAIL flush_busy: got stall %b out %h want stall 0 out 000003eb", ix_stall, alu_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ix_stall !== 1'b0) begin errors++; $display("FAIL flush_hold: got %b want 0", ix_stall); end
    run_md(3'd4, 32'd1000, 32'd3, n, r);
    checks++;
    if (r !== 32'd333 || n !== 33) begin errors++; $display("FAIL after_flush: got %h in %0d want 0000014d in 33", r, n); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] r;
    @(negedge clk);
    idle_inputs();
    dataR1_in = 32'd77; dataR2_in = 32'd5; inst_in = md_inst(3'd5);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ix_stall !== 1'b0 || alu_out !== 32'd82) begin
      errors++; $display("FAIL reset_mid: got stall %b out %h want stall 0 out 00000052", ix_stall, alu_out);
    end
    @(negedge clk);
    inst_in = NOP;
    rst = 1'b1;
    run_md(3'd7, 32'd77, 32'd5, n, r);
    checks++;
    if (r !== 32'd2 || n !== 33) begin errors++; $display("FAIL after_reset: got %h in %0d want 00000002 in 33", r, n); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random(1'b0);
`ifdef IX_MULDIV_EN
    test_muldiv_basic();
    test_div_special();
    test_muldiv_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`else
    test_alu_random(1'b1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
